comparator_seq: RTL and testbench

// Sequencing initiator for the SEL-coded N-bit comparator (SEL 000..111: 0, 1, ==, !=, >=, <=, <, >).

---
 rtl/comparator_seq.sv | 111 +++++++++++
 tb/tb_comparator_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/comparator_seq.sv
// Sequencing initiator for a shared SEL-coded comparator: steps one opcode per
// cycle over a captured operand pair and returns a decoded EQ/LT/GT relation.
module comparator_seq #(
  parameter int N        = 8,
  parameter int SELFTEST = 0,
  parameter int CHECK    = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic [2:0]   cmp_sel,
  output logic [N-1:0] cmp_value1,
  output logic [N-1:0] cmp_value2,
  input  logic         cmp_out,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         res_eq,
  output logic         res_lt,
  output logic         res_gt,
  output logic         res_err,
  output logic         busy
);

  typedef enum logic [2:0] {
    IDLE, ST0, ST1, PH_EQ, PH_LT, PH_GT, DONE
  } state_t;

  state_t state, nxt;
  logic   accept;

  assign accept = in_valid & in_ready;
  assign busy   = (state != IDLE);

  function automatic logic [2:0] sel_of(input state_t s);
    case (s)
      ST1:     sel_of = 3'b001;
      PH_EQ:   sel_of = 3'b010;
      PH_LT:   sel_of = 3'b110;
      PH_GT:   sel_of = 3'b111;
      default: sel_of = 3'b000;
    endcase
  endfunction

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = (SELFTEST != 0) ? ST0 : PH_EQ;
      ST0:     nxt = ST1;
      ST1:     nxt = PH_EQ;
      PH_EQ:   nxt = cmp_out ? DONE : PH_LT;
      PH_LT:   nxt = (CHECK != 0) ? PH_GT : DONE;
      PH_GT:   nxt = DONE;
      DONE:    if (res_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // cmp_sel, in_ready and res_valid are registered from the next state so they
  // line up with the state register; cmp_out is consumed in the cycle it is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cmp_sel    <= '0;
      cmp_value1 <= '0;
      cmp_value2 <= '0;
      in_ready   <= 1'b0;
      res_valid  <= 1'b0;
      res_eq     <= 1'b0;
      res_lt     <= 1'b0;
      res_gt     <= 1'b0;
      res_err    <= 1'b0;
    end else begin
      state     <= nxt;
      cmp_sel   <= sel_of(nxt);
      in_ready  <= (nxt == IDLE);
      res_valid <= (nxt == DONE);
      case (state)
        IDLE: if (accept) begin
          cmp_value1 <= in_a;
          cmp_value2 <= in_b;
          res_eq     <= 1'b0;
          res_lt     <= 1'b0;
          res_gt     <= 1'b0;
          res_err    <= 1'b0;
        end
        ST0: res_err <= res_err | cmp_out;
        ST1: res_err <= res_err | ~cmp_out;
        PH_EQ: begin
          res_eq <= cmp_out;
          if (cmp_out) begin
            res_lt <= 1'b0;
            res_gt <= 1'b0;
          end
        end
        PH_LT: begin
          res_lt <= cmp_out;
          if (CHECK == 0) res_gt <= ~cmp_out;
        end
        PH_GT: begin
          res_gt  <= cmp_out;
          res_err <= res_err | (cmp_out == res_lt);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_seq.sv
// Bench for comparator_seq: two instances (plain, self-test) each driving a
// behavioural comparator with injectable faults, checked against a value-level model.
module tb_comparator_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] in_valid = '0, in_ready, res_valid, res_ready = '0, busy;
  logic [1:0] res_eq, res_lt, res_gt, res_err, cmp_out;
  logic [7:0] in_a[2], in_b[2], cmp_value1[2], cmp_value2[2];
  logic [2:0] cmp_sel[2];
  logic [1:0] fault[2];

  int total = 0;
  int bad   = 0;

  // per-instance expectation and observation
  logic       active[2];
  logic       seen[2];
  int         got_n[2], exp_n[2];
  logic [2:0] got_sel[2][8], exp_sel[2][6];
  logic [3:0] exp_res[2];
  logic [7:0] exp_a[2], exp_b[2];

  always #5 clk = ~clk;

  comparator_seq #(.N(8), .SELFTEST(0), .CHECK(1)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(in_a[0]), .in_b(in_b[0]), .cmp_sel(cmp_sel[0]), .cmp_value1(cmp_value1[0]),
    .cmp_value2(cmp_value2[0]), .cmp_out(cmp_out[0]), .res_valid(res_valid[0]),
    .res_ready(res_ready[0]), .res_eq(res_eq[0]), .res_lt(res_lt[0]), .res_gt(res_gt[0]),
    .res_err(res_err[0]), .busy(busy[0]));

  comparator_seq #(.N(8), .SELFTEST(1), .CHECK(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(in_a[1]), .in_b(in_b[1]), .cmp_sel(cmp_sel[1]), .cmp_value1(cmp_value1[1]),
    .cmp_value2(cmp_value2[1]), .cmp_out(cmp_out[1]), .res_valid(res_valid[1]),
    .res_ready(res_ready[1]), .res_eq(res_eq[1]), .res_lt(res_lt[1]), .res_gt(res_gt[1]),
    .res_err(res_err[1]), .busy(busy[1]));

  // fault 0: healthy, 1: OUT stuck 0, 2: OUT forced 1 for SEL 111 when a<b
  function automatic logic cmpf(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b,
                                input logic [1:0] f);
    if (f == 2'd1) return 1'b0;
    if (f == 2'd2 && s == 3'b111 && a < b) return 1'b1;
    case (s)
      3'b000: return 1'b0;
      3'b001: return 1'b1;
      3'b010: return a == b;
      3'b011: return a != b;
      3'b100: return a >= b;
      3'b101: return a <= b;
      3'b110: return a < b;
      default: return a > b;
    endcase
  endfunction

  assign cmp_out[0] = cmpf(cmp_sel[0], cmp_value1[0], cmp_value2[0], fault[0]);
  assign cmp_out[1] = cmpf(cmp_sel[1], cmp_value1[1], cmp_value2[1], fault[1]);

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Value-level model: list of opcodes asked of the comparator and the relation derived.
  task automatic model(input int k, input logic [7:0] a, input logic [7:0] b, input logic [1:0] f,
                       input bit st);
    logic o, eq, lt, gt, err;
    int n = 0;
    err = 0; lt = 0; gt = 0;
    if (st) begin
      exp_sel[k][n++] = 3'b000; err |= cmpf(3'b000, a, b, f);
      exp_sel[k][n++] = 3'b001; err |= !cmpf(3'b001, a, b, f);
    end
    exp_sel[k][n++] = 3'b010; eq = cmpf(3'b010, a, b, f);
    if (!eq) begin
      exp_sel[k][n++] = 3'b110; lt = cmpf(3'b110, a, b, f);
      exp_sel[k][n++] = 3'b111; o = cmpf(3'b111, a, b, f);
      gt = o; err |= (o == lt);
    end
    exp_n[k] = n;
    exp_res[k] = {eq, lt, gt, err};
    exp_a[k] = a;
    exp_b[k] = b;
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (active[k]) begin
        if (!res_valid[k]) begin
          if (busy[k]) begin
            if (got_n[k] < 8) got_sel[k][got_n[k]] = cmp_sel[k];
            got_n[k]++;
          end
        end else begin
          if (!seen[k]) begin
            seen[k] = 1'b1;
            check("seq_len", got_n[k], exp_n[k]);
            for (int i = 0; i < exp_n[k] && i < got_n[k]; i++)
              check("sel_seq", int'(got_sel[k][i]), int'(exp_sel[k][i]));
          end
          check("result", int'({res_eq[k], res_lt[k], res_gt[k], res_err[k]}), int'(exp_res[k]));
          check("sel_done", int'(cmp_sel[k]), 0);
        end
        check("in_ready_busy", int'(in_ready[k]), 0);
        check("value1", int'(cmp_value1[k]), int'(exp_a[k]));
        check("value2", int'(cmp_value2[k]), int'(exp_b[k]));
      end else if (rst_n && busy[k]) begin
        check("idle_busy", int'(busy[k]), 0);
      end
    end
  end

  task automatic wait_ready(input int k);
    for (int i = 0; i < 20 && !in_ready[k]; i++) @(negedge clk);
    check("in_ready_timeout", int'(in_ready[k]), 1);
  endtask

  task automatic send(input int k, input logic [7:0] a, input logic [7:0] b, input logic [1:0] f);
    fault[k] = f;
    model(k, a, b, f, k == 1);
    wait_ready(k);
    in_a[k] = a; in_b[k] = b; in_valid[k] = 1'b1;
    @(posedge clk); #1;
    active[k] = 1'b1; seen[k] = 1'b0; got_n[k] = 0;
    in_valid[k] = 1'b0;
    in_a[k] = 8'($urandom); in_b[k] = 8'($urandom);
  endtask

  task automatic do_pair(input int k, input logic [7:0] a, input logic [7:0] b, input logic [1:0] f,
                         input int hold, input bit use_lit, input logic [3:0] lit);
    send(k, a, b, f);
    for (int i = 0; i < 20 && !res_valid[k]; i++) @(negedge clk);
    check("res_valid_timeout", int'(res_valid[k]), 1);
    if (use_lit)
      check("literal", int'({res_eq[k], res_lt[k], res_gt[k], res_err[k]}), int'(lit));
    for (int i = 0; i < hold; i++) begin
      in_valid[k] = 1'b1; in_a[k] = 8'($urandom); in_b[k] = 8'($urandom);
      @(negedge clk);
    end
    res_ready[k] = 1'b1;
    @(posedge clk); #1;
    res_ready[k] = 1'b0; in_valid[k] = 1'b0; active[k] = 1'b0;
    check("in_ready_after", int'(in_ready[k]), 1);
  endtask

  initial begin
    logic [7:0] a, b;
    active[0] = 0; active[1] = 0; seen[0] = 0; seen[1] = 0;
    got_n[0] = 0; got_n[1] = 0; fault[0] = 0; fault[1] = 0;
    in_a[0] = 0; in_a[1] = 0; in_b[0] = 0; in_b[1] = 0;
    #1;
    check("reset_outs", int'({in_ready, res_valid, busy, res_eq, res_lt, res_gt, res_err}), 0);
    check("reset_sel", int'({cmp_sel[0], cmp_sel[1]}), 0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", int'(in_ready), 3);

    // pin the model
    model(0, 8'h3C, 8'h3C, 0, 0);
    check("model_eq_n", exp_n[0], 1);
    check("model_eq_res", int'(exp_res[0]), 4'b1000);
    model(0, 8'h05, 8'hF0, 2, 0);
    check("model_fault_res", int'(exp_res[0]), 4'b0111);
    model(1, 8'h05, 8'hF0, 1, 1);
    check("model_st_n", exp_n[1], 5);
    check("model_st_res", int'(exp_res[1]), 4'b0001);

    // directed cases
    do_pair(0, 8'h3C, 8'h3C, 0, 0, 1, 4'b1000);
    do_pair(0, 8'h05, 8'hF0, 0, 0, 1, 4'b0100);
    do_pair(0, 8'hF0, 8'h05, 0, 0, 1, 4'b0010);
    do_pair(0, 8'h05, 8'hF0, 2, 0, 1, 4'b0111);
    do_pair(1, 8'h05, 8'hF0, 1, 0, 1, 4'b0001);
    do_pair(1, 8'h3C, 8'h3C, 0, 0, 1, 4'b1000);
    do_pair(0, 8'h00, 8'hFF, 0, 5, 1, 4'b0100);
    do_pair(0, 8'hFF, 8'hFF, 0, 0, 1, 4'b1000);
    do_pair(0, 8'hFF, 8'hFE, 0, 0, 1, 4'b0010);

    // abort during the LT phase
    send(0, 8'h05, 8'hF0, 0);
    for (int i = 0; i < 10 && cmp_sel[0] != 3'b110; i++) @(negedge clk);
    check("reached_lt", int'(cmp_sel[0]), 3'b110);
    active[0] = 1'b0;
    rst_n = 1'b0; #1;
    check("abort_outs", int'({in_ready, res_valid, busy, res_eq, res_lt, res_gt, res_err}), 0);
    check("abort_sel", int'({cmp_sel[0], cmp_sel[1]}), 0);
    check("abort_vals", int'({cmp_value1[0], cmp_value2[0]}), 0);
    @(negedge clk); rst_n = 1'b1;
    do_pair(0, 8'h00, 8'hFF, 0, 0, 1, 4'b0100);

    // randomized traffic against the model
    for (int n = 0; n < 60; n++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : 8'($urandom);
      do_pair(n % 2, a, b, 2'($urandom_range(0, 4) == 0 ? $urandom_range(1, 2) : 0),
              $urandom_range(0, 3), 0, 4'b0000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

endmodule
